serial_subtractor_n: RTL
========================

// Module: serial_subtractor_n
// PURPOSE
//  Parametrised multi-cycle subtractor with borrow-in: computes D = X - Y - BIN.
//  Generalises the 4-bit combinational subtractor to any WIDTH.
//  Processes DIGIT bits per clock from the LSB, rippling the borrow through a register.
//  Uses a start/busy/done handshake so a controller or bench can sequence operations.
// PARAMETERS
//  WIDTH   16   operand/result width in bits (>= 2)
//  DIGIT    4   bits processed per cycle; WIDTH % DIGIT == 0 is required (1 <= DIGIT <= WIDTH)
//  NDIG     WIDTH/DIGIT (localparam) number of RUN cycles
// PORTS
//  clk    in   1      single clock, all state updates on rising edge
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only in IDLE
//  x      in   WIDTH  minuend, captured on accepted start
//  y      in   WIDTH  subtrahend, captured on accepted start
//  bin    in   1      borrow-in, captured on accepted start
//  busy   out  1      high in RUN and DONE
//  done   out  1      one-cycle pulse, result valid
//  d      out  WIDTH  difference, held until next completion
//  bout   out  1      borrow out of MSB (1 iff x < y + bin, unsigned)
//  ovf    out  1      two's-complement overflow of x - y - bin
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, d=0, bout=0, ovf=0.
//    All internal operand, borrow and count registers are cleared.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: at an edge with start=1:
//    - latch x, y, bin into shift regs; borrow reg = bin; cnt = 0
//    - go to RUN
//  IDLE with start=0: hold.
//  RUN, each edge:
//    - {b, dig} = x_sh[DIGIT-1:0] - y_sh[DIGIT-1:0] - borrow (DIGIT+1-bit arithmetic)
//    - borrow <= b
//    - shift dig into partial result from the top; shift x_sh and y_sh right by DIGIT
//    - cnt++
//  On the edge where cnt == NDIG-1: commit d <= full result, bout <= final borrow,
//    ovf <= (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]), using latched operands; go to DONE.
//  DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
//  Latency: start accepted at edge k; done high during the cycle after edge k+NDIG.
//    Next start accepted at edge k+NDIG+1 at the earliest.
//  busy = (state != IDLE); done = (state == DONE); both decoded from state, glitch-free regs.
//  start while busy (RUN or DONE) is ignored; no queuing.
//    Inputs x/y/bin may change freely after acceptance.
//  d/bout/ovf change only on the commit edge. During RUN they show the previous result.
//  Wrap-around: result is modulo 2^WIDTH, e.g. 0 - 1 = all ones with bout=1.
//  Reset mid-RUN/DONE: immediate return to IDLE, outputs cleared, no done pulse.
//  DIGIT == WIDTH degenerates to NDIG=1 (single RUN cycle); DIGIT=1 is bit-serial.
// TESTING (WIDTH=16, DIGIT=4 unless noted)
//  1. x=16'h1234 y=16'h0234 bin=0, start at edge k
//     -> busy from k; done only in the cycle after edge k+4
//     -> d=16'h1000, bout=0, ovf=0
//  2. x=0 y=1 bin=0 -> d=16'hFFFF bout=1 ovf=0
//     x=5 y=5 bin=1 -> d=16'hFFFF bout=1
//  3. x=16'h8000 y=1 bin=0 -> d=16'h7FFF bout=0 ovf=1
//     x=16'h7FFF y=16'hFFFF -> d=16'h8000 bout=1 ovf=1
//  4. Pulse start again at edges k+1..k+4 with other operands -> ignored
//     -> result is that of the first op; only one done pulse
//  5. rst_n=0 at edge k+2 of a run -> busy=0 done=0 d=0 at once
//     -> no done afterwards; a new start then works normally
//  6. WIDTH=4 with DIGIT=1, 2 and 4: exhaustive 512-case sweep of {bin,x,y}
//     -> d == (x-y-bin) mod 16, bout/ovf match the reference model
//     -> done exactly NDIG+1 edges after each start

Source files
------------

// File: rtl/serial_subtractor_n.sv
// Multi-cycle subtractor D = X - Y - BIN, DIGIT bits per clock from the LSB,
// with the borrow rippled through a register and a start/busy/done handshake.

module serial_subtractor_n_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bi,
  output logic [DIGIT-1:0] dig,
  output logic             bo
);
  logic [DIGIT:0] s;

  // One spare bit on top: a negative difference lands there as the borrow.
  assign s   = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bi};
  assign dig = s[DIGIT-1:0];
  assign bo  = s[DIGIT];
endmodule

module serial_subtractor_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             xs_q, xs_d, ys_q, ys_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [DIGIT-1:0] dig;
  logic             dig_b;
  logic [WIDTH-1:0] res_full;

  serial_subtractor_n_digit #(.DIGIT(DIGIT)) u_digit (
    .a   (x_sh_q[DIGIT-1:0]),
    .b   (y_sh_q[DIGIT-1:0]),
    .bi  (brw_q),
    .dig (dig),
    .bo  (dig_b)
  );

  // Earlier digits collect below the current one; a single-digit build needs no store.
  if (NDIG > 1) begin : g_part
    logic [WIDTH-DIGIT-1:0] part_q, part_d;

    assign res_full = {dig, part_q};

    always_comb begin
      part_d = part_q;
      if (state_q == IDLE && start) part_d = '0;
      else if (state_q == RUN)      part_d = res_full[WIDTH-1:DIGIT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) part_q <= '0;
      else        part_q <= part_d;
    end
  end else begin : g_single
    assign res_full = dig;
  end

  always_comb begin
    state_d = state_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        x_sh_d  = x;
        y_sh_d  = y;
        brw_d   = bin;
        cnt_d   = '0;
        xs_d    = x[WIDTH-1];
        ys_d    = y[WIDTH-1];
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        x_sh_d = x_sh_q >> DIGIT;
        y_sh_d = y_sh_q >> DIGIT;
        brw_d  = dig_b;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          d_d     = res_full;
          bout_d  = dig_b;
          // Overflow only possible when operand signs differ and the result flips sign.
          ovf_d   = (xs_q != ys_q) && (res_full[WIDTH-1] != xs_q);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_sh_q  <= '0;
      y_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_sh_q  <= x_sh_d;
      y_sh_q  <= y_sh_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
endmodule
